// File: rtl/sys_arr_pkg.sv
// Shared types and constants for the systolic-array MAC driver slice.
package sys_arr_pkg;

    localparam int DW = 16;
    localparam logic [DW-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FIRE = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } mac_drv_state_t;

endpackage

// File: rtl/sysarr_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT-1.
module sysarr_timeout_ctr #(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    assign o_tc = (r_count == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/sysarr_mac_driver.sv
// Issue engine for one MAC PE: takes an operand triple, sequences load/start/wait,
// and returns the PE's out_accumulate (or a QNaN timeout abort) on a valid/ready port.
module sysarr_mac_driver
    import sys_arr_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [DW-1:0] op_x,
    input  logic [DW-1:0] op_weight,
    input  logic [DW-1:0] op_acc,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_timeout,
    output logic          busy,
    output logic [DW-1:0] mac_in_value,
    output logic          mac_shift,
    output logic          mac_start,
    output logic [DW-1:0] mac_weight,
    output logic [DW-1:0] mac_in_accumulate,
    input  logic          mac_value_ready,
    input  logic [DW-1:0] mac_out_accumulate
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never waits on ready, and res_data/res_timeout stay
    // stable while res_valid is high until that transfer.

    mac_drv_state_t r_state;
    mac_drv_state_t w_next_state;

    logic [DW-1:0] r_x_hold;
    logic [DW-1:0] r_w_hold;
    logic [DW-1:0] r_acc_hold;
    logic [DW-1:0] r_res_data;
    logic          r_res_timeout;
    logic          r_saw_busy;

    logic w_accept;
    logic w_capture;
    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_tmr_tc;
    logic w_drive_pe;

    sysarr_timeout_ctr #(
        .TIMEOUT(TIMEOUT),
        .TMR_W  (TMR_W)
    ) u_timeout_ctr (
        .clk  (clk),
        .rst  (RST),
        .i_clr(w_tmr_clr),
        .i_en (w_tmr_en),
        .o_tc (w_tmr_tc)
    );

    // Capture only after the PE has been seen busy, so a stale ready is never taken as done.
    assign w_accept  = op_valid & op_ready;
    assign w_capture = (r_state == WAIT) & r_saw_busy & mac_value_ready;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (op_valid) w_next_state = LOAD;
            LOAD: w_next_state = FIRE;
            FIRE: w_next_state = WAIT;
            WAIT: if (w_capture || w_tmr_tc) w_next_state = DONE;
            DONE: if (res_ready) w_next_state = op_valid ? LOAD : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        op_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        mac_shift  = 1'b0;
        mac_start  = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_en   = 1'b0;
        w_drive_pe = 1'b1;
        case (r_state)
            IDLE: begin
                op_ready   = 1'b1;
                busy       = 1'b0;
                w_drive_pe = 1'b0;
            end
            LOAD: mac_shift = 1'b1;
            FIRE: begin
                mac_start = 1'b1;
                w_tmr_clr = 1'b1;
            end
            WAIT: w_tmr_en = 1'b1;
            DONE: begin
                res_valid = 1'b1;
                op_ready  = res_ready;
            end
            default: begin
                busy       = 1'b0;
                w_drive_pe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_x_hold      <= '0;
            r_w_hold      <= '0;
            r_acc_hold    <= '0;
            r_res_data    <= '0;
            r_res_timeout <= 1'b0;
            r_saw_busy    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x_hold   <= op_x;
                r_w_hold   <= op_weight;
                r_acc_hold <= op_acc;
                r_saw_busy <= 1'b0;
            end
            if ((r_state == FIRE || r_state == WAIT) && !mac_value_ready) begin
                r_saw_busy <= 1'b1;
            end
            if (w_capture) begin
                r_res_data    <= mac_out_accumulate;
                r_res_timeout <= 1'b0;
            end else if (r_state == WAIT && w_tmr_tc) begin
                r_res_data    <= FP16_QNAN;
                r_res_timeout <= 1'b1;
            end
        end
    end

    assign res_data          = r_res_data;
    assign res_timeout       = r_res_timeout;
    assign mac_in_value      = mac_shift ? r_x_hold : '0;
    assign mac_weight        = w_drive_pe ? r_w_hold : '0;
    assign mac_in_accumulate = w_drive_pe ? r_acc_hold : '0;

endmodule

// File: tb/tb_sysarr_mac_driver.sv
// Directed bench for sysarr_mac_driver with a behavioural PE model.
module tb_sysarr_mac_driver;

  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int WAIT_BOUND = TIMEOUT + 40;

  logic          clk = 1'b0;
  logic          RST;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_x;
  logic [DW-1:0] op_weight;
  logic [DW-1:0] op_acc;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_timeout;
  logic          busy;
  logic [DW-1:0] mac_in_value;
  logic          mac_shift;
  logic          mac_start;
  logic [DW-1:0] mac_weight;
  logic [DW-1:0] mac_in_accumulate;
  logic          mac_value_ready;
  logic [DW-1:0] mac_out_accumulate;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sysarr_mac_driver #(.TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .RST                (RST),
    .op_valid           (op_valid),
    .op_ready           (op_ready),
    .op_x               (op_x),
    .op_weight          (op_weight),
    .op_acc             (op_acc),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .res_timeout        (res_timeout),
    .busy               (busy),
    .mac_in_value       (mac_in_value),
    .mac_shift          (mac_shift),
    .mac_start          (mac_start),
    .mac_weight         (mac_weight),
    .mac_in_accumulate  (mac_in_accumulate),
    .mac_value_ready    (mac_value_ready),
    .mac_out_accumulate (mac_out_accumulate)
  );

  // ---------------- behavioural PE ----------------
  // mode 0: real-ish PE (ready drops with start, returns after pe_lat cycles)
  // mode 1: ready stuck low; mode 2: ready stuck high
  int pe_mode = 0;
  int pe_lat  = 2;
  logic          pe_run;
  int            pe_cnt;
  logic [DW-1:0] pe_x;
  logic [DW-1:0] pe_out;

  function automatic logic [DW-1:0] pe_func(input logic [DW-1:0] x, input logic [DW-1:0] w,
                                            input logic [DW-1:0] a);
    case ({x, w, a})
      {16'h4000, 16'h4200, 16'h3C00}: return 16'h4700;
      {16'h3C00, 16'h3C00, 16'h0000}: return 16'h3C00;
      {16'h3C00, 16'h4000, 16'h3C00}: return 16'h4200;
      {16'h4200, 16'h4200, 16'h0000}: return 16'h4880;
      {16'h3800, 16'h4000, 16'hBC00}: return 16'h0000;
      default:                        return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      pe_run <= 1'b0;
      pe_cnt <= 0;
      pe_x   <= '0;
      pe_out <= '0;
    end else begin
      if (mac_shift) pe_x <= mac_in_value;
      if (mac_start) begin
        pe_run <= 1'b1;
        pe_cnt <= pe_lat;
        pe_out <= pe_func(pe_x, mac_weight, mac_in_accumulate);
      end else if (pe_run) begin
        if (pe_cnt <= 1) pe_run <= 1'b0;
        pe_cnt <= pe_cnt - 1;
      end
    end
  end

  always_comb begin
    mac_value_ready = 1'b1;
    case (pe_mode)
      0:       mac_value_ready = !(pe_run || mac_start);
      1:       mac_value_ready = 1'b0;
      default: mac_value_ready = 1'b1;
    endcase
  end

  assign mac_out_accumulate = pe_out;

  // ---------------- protocol monitor ----------------
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_start = 0;
  int   n_shift = 0;
  int   n_overlap = 0;
  int   n_order_err = 0;
  logic prev_shift = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mac_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
      if (!prev_shift) n_order_err <= n_order_err + 1;
    end
    if (mac_shift) n_shift <= n_shift + 1;
    if (mac_shift && mac_start) n_overlap <= n_overlap + 1;
    prev_shift <= mac_shift;
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_res(input string name);
    int t;
    t = 0;
    while (!res_valid && t < WAIT_BOUND) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_res_valid"}, {31'd0, res_valid}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic [DW-1:0] acc;
    int            mode;
    int            lat;
    logic [DW-1:0] exp_data;
    logic          exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string tag);
    int s_start, s_shift, s_ovl, s_ord;
    pe_mode = v.mode;
    pe_lat  = v.lat;
    s_start = n_start;
    s_shift = n_shift;
    s_ovl   = n_overlap;
    s_ord   = n_order_err;
    exp_q.push_back(v.exp_data);
    op_x      = v.x;
    op_weight = v.w;
    op_acc    = v.acc;
    op_valid  = 1'b1;
    res_ready = 1'b0;
    chk({tag, "_op_ready_idle"}, {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    op_valid  = 1'b0;
    op_x      = '0;
    op_weight = '0;
    op_acc    = '0;
    wait_res(tag);
    chk({tag, "_res_data"}, {16'd0, res_data}, {16'd0, exp_q.pop_front()});
    chk({tag, "_res_timeout"}, {31'd0, res_timeout}, {31'd0, v.exp_to});
    chk({tag, "_start_count"}, n_start - s_start, 32'd1);
    chk({tag, "_shift_count"}, n_shift - s_shift, 32'd1);
    chk({tag, "_no_overlap"}, n_overlap - s_ovl, 32'd0);
    chk({tag, "_start_after_shift"}, n_order_err - s_ord, 32'd0);
    if (v.exp_to) chk({tag, "_timeout_latency"}, cyc - start_cyc, TIMEOUT + 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_idle_after_drain"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b1;
    op_valid = 1'b0;
    op_x = '0;
    op_weight = '0;
    op_acc = '0;
    res_ready = 1'b0;

    vecs[0] = '{16'h4000, 16'h4200, 16'h3C00, 0, 3, 16'h4700, 1'b0};
    vecs[1] = '{16'h3C00, 16'h3C00, 16'h0000, 0, 1, 16'h3C00, 1'b0};
    vecs[2] = '{16'h3C00, 16'h4000, 16'h3C00, 0, 5, 16'h4200, 1'b0};
    vecs[3] = '{16'h4200, 16'h4200, 16'h0000, 0, 2, 16'h4880, 1'b0};
    vecs[4] = '{16'h3800, 16'h4000, 16'hBC00, 0, 4, 16'h0000, 1'b0};
    vecs[5] = '{16'h4000, 16'h4200, 16'h3C00, 1, 2, 16'h7E00, 1'b1};
    vecs[6] = '{16'h3C00, 16'h3C00, 16'h0000, 2, 2, 16'h7E00, 1'b1};

    @(negedge clk);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_shift_start", {30'd0, mac_shift, mac_start}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_mac_weight", {16'd0, mac_weight}, 32'd0);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // back-to-back: second triple accepted on the drain cycle of the first
    pe_mode = 0;
    pe_lat  = 2;
    op_x = 16'h4000; op_weight = 16'h4200; op_acc = 16'h3C00;
    op_valid  = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    op_x = 16'h3C00; op_weight = 16'h3C00; op_acc = 16'h0000;
    wait_res("b2b_first");
    chk("b2b_first_data", {16'd0, res_data}, 32'h4700);
    chk("b2b_op_ready_in_done", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
    chk("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
    chk("b2b_load_shift", {31'd0, mac_shift}, 32'd1);
    chk("b2b_load_x", {16'd0, mac_in_value}, 32'h3C00);
    wait_res("b2b_second");
    chk("b2b_second_data", {16'd0, res_data}, 32'h3C00);
    chk("b2b_second_timeout", {31'd0, res_timeout}, 32'd0);
    @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // backpressure: result held, no accept, no new start
    op_x = 16'h4000; op_weight = 16'h4200; op_acc = 16'h3C00;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    wait_res("bp");
    op_x = 16'h4200; op_weight = 16'h4200; op_acc = 16'h0000;
    op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_data_%0d", i), {16'd0, res_data}, 32'h4700);
      chk($sformatf("bp_op_ready_%0d", i), {31'd0, op_ready}, 32'd0);
      chk($sformatf("bp_start_%0d", i), {31'd0, mac_start}, 32'd0);
      chk($sformatf("bp_res_valid_%0d", i), {31'd0, res_valid}, 32'd1);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of WAIT
    pe_mode = 0;
    pe_lat  = 20;
    op_x = 16'h4200; op_weight = 16'h4200; op_acc = 16'h0000;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_in_wait", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_shift_start", {30'd0, mac_shift, mac_start}, 32'd0);
    chk("midrst_mac_data", {mac_weight, mac_in_accumulate}, 32'd0);
    chk("midrst_res", {15'd0, res_timeout, res_data}, 32'd0);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
